// File: rtl/motor_pwm_driver_if.sv
// Command/PWM bundle for the motor PWM driver: the controller drives the
// enable and commands, and the driver returns the PWM and status signals.
interface motor_pwm_driver_if #(
    parameter int cmd_l = 4
);
    logic             en;
    logic [cmd_l-1:0] speed_cmd;
    logic [cmd_l-1:0] dir_cmd;
    logic             pwm_l;
    logic             pwm_r;
    logic [cmd_l-1:0] duty_l;
    logic [cmd_l-1:0] duty_r;
    logic             period_end;
    logic             busy;

    modport master (
        output en, speed_cmd, dir_cmd,
        input  pwm_l, pwm_r, duty_l, duty_r, period_end, busy
    );

    modport slave (
        input  en, speed_cmd, dir_cmd,
        output pwm_l, pwm_r, duty_l, duty_r, period_end, busy
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// Differential-drive PWM generator: mixes speed/direction into clamped left/right
// duties, applies them per PWM period, and drains the running period on disable.
module motor_pwm_driver #(
    parameter int cmd_l       = 4,
    parameter int def_dir_cmd = 8,
    parameter int presc       = 4
) (
    input  logic               clk,
    input  logic               rst,
    motor_pwm_driver_if.slave  bus
);
    localparam int MAX = (1 << cmd_l) - 1;
    localparam int W   = cmd_l + 2;
    localparam int PW  = (presc > 1) ? $clog2(presc) : 1;

    localparam logic signed [W-1:0] DEF_DIR   = W'(def_dir_cmd);
    localparam logic [PW-1:0]       PRE_LAST  = PW'(presc - 1);
    localparam logic [cmd_l-1:0]    SLOT_LAST = cmd_l'(MAX - 1);

    typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [cmd_l-1:0] slot_q, slot_d;
    logic [cmd_l-1:0] duty_l_q, duty_l_d;
    logic [cmd_l-1:0] duty_r_q, duty_r_d;

    logic signed [W-1:0] turn, left_raw, right_raw;
    logic [cmd_l-1:0]    mix_l, mix_r;
    logic                active, tick, period_end;

    // Headroom of two bits keeps speed +/- turn exact before clamping.
    function automatic logic [cmd_l-1:0] clamp(input logic signed [W-1:0] v);
        if (v[W-1])
            return '0;
        else if (v[cmd_l])
            return cmd_l'(MAX);
        else
            return v[cmd_l-1:0];
    endfunction

    always_comb begin
        turn      = $signed({2'b00, bus.dir_cmd}) - DEF_DIR;
        left_raw  = $signed({2'b00, bus.speed_cmd}) + turn;
        right_raw = $signed({2'b00, bus.speed_cmd}) - turn;
        mix_l     = clamp(left_raw);
        mix_r     = clamp(right_raw);
    end

    assign active     = (state_q != S_OFF);
    assign tick       = (pre_q == PRE_LAST);
    assign period_end = active && tick && (slot_q == SLOT_LAST);

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        slot_d   = slot_q;
        duty_l_d = duty_l_q;
        duty_r_d = duty_r_q;

        if (active) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick)
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + cmd_l'(1);
        end

        case (state_q)
            S_OFF: begin
                pre_d    = '0;
                slot_d   = '0;
                duty_l_d = '0;
                duty_r_d = '0;
                if (bus.en) begin
                    state_d  = S_RUN;
                    duty_l_d = mix_l;
                    duty_r_d = mix_r;
                end
            end
            S_RUN: begin
                if (!bus.en)
                    state_d = S_DRAIN;
                else if (period_end) begin
                    duty_l_d = mix_l;
                    duty_r_d = mix_r;
                end
            end
            S_DRAIN: begin
                if (period_end) begin
                    state_d  = S_OFF;
                    duty_l_d = '0;
                    duty_r_d = '0;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_OFF;
            pre_q    <= '0;
            slot_q   <= '0;
            duty_l_q <= '0;
            duty_r_q <= '0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            slot_q   <= slot_d;
            duty_l_q <= duty_l_d;
            duty_r_q <= duty_r_d;
        end
    end

    assign bus.pwm_l      = active && (slot_q < duty_l_q);
    assign bus.pwm_r      = active && (slot_q < duty_r_q);
    assign bus.duty_l     = duty_l_q;
    assign bus.duty_r     = duty_r_q;
    assign bus.period_end = period_end;
    assign bus.busy       = active;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: two instances (presc=1 and presc=4) share stimulus and
// are checked every cycle against a period-position model, plus directed sequences.
module tb_motor_pwm_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] speed = '0;
    logic [3:0] dir = 4'd8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    motor_pwm_driver_if #(.cmd_l(4)) b1 ();
    motor_pwm_driver_if #(.cmd_l(4)) b4 ();

    assign b1.en = en;
    assign b1.speed_cmd = speed;
    assign b1.dir_cmd = dir;
    assign b4.en = en;
    assign b4.speed_cmd = speed;
    assign b4.dir_cmd = dir;

    motor_pwm_driver #(.cmd_l(4), .def_dir_cmd(8), .presc(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    motor_pwm_driver #(.cmd_l(4), .def_dir_cmd(8), .presc(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    // Model: mode 0=off 1=run 2=drain; cyc = clk cycles into current period.
    int m_mode[2];
    int m_cyc[2];
    int m_dl[2];
    int m_dr[2];
    int PR[2] = '{1, 4};

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > 15) return 15;
        return v;
    endfunction

    task automatic model_step(input int k);
        int per;
        bit pe;
        per = 15 * PR[k];
        pe = (m_mode[k] != 0) && (m_cyc[k] == per - 1);
        if (!rst) begin
            m_mode[k] = 0; m_cyc[k] = 0; m_dl[k] = 0; m_dr[k] = 0;
        end else begin
            case (m_mode[k])
                0: if (en) begin
                    m_mode[k] = 1; m_cyc[k] = 0;
                    m_dl[k] = clampi(int'(speed) + (int'(dir) - 8));
                    m_dr[k] = clampi(int'(speed) - (int'(dir) - 8));
                end
                1: begin
                    m_cyc[k] = (m_cyc[k] + 1) % per;
                    if (!en) m_mode[k] = 2;
                    else if (pe) begin
                        m_dl[k] = clampi(int'(speed) + (int'(dir) - 8));
                        m_dr[k] = clampi(int'(speed) - (int'(dir) - 8));
                    end
                end
                default: begin
                    m_cyc[k] = (m_cyc[k] + 1) % per;
                    if (pe) begin
                        m_mode[k] = 0; m_cyc[k] = 0; m_dl[k] = 0; m_dr[k] = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp_one(input int k, input logic pl, input logic pr, input logic [3:0] dl,
                           input logic [3:0] dr, input logic pe, input logic bz);
        bit on;
        int slot;
        on = (m_mode[k] != 0);
        slot = m_cyc[k] / PR[k];
        check($sformatf("m%0d_pwm_l", PR[k]), 32'(pl), 32'(on && slot < m_dl[k]));
        check($sformatf("m%0d_pwm_r", PR[k]), 32'(pr), 32'(on && slot < m_dr[k]));
        check($sformatf("m%0d_duty_l", PR[k]), 32'(dl), m_dl[k]);
        check($sformatf("m%0d_duty_r", PR[k]), 32'(dr), m_dr[k]);
        check($sformatf("m%0d_period_end", PR[k]), 32'(pe), 32'(on && m_cyc[k] == 15 * PR[k] - 1));
        check($sformatf("m%0d_busy", PR[k]), 32'(bz), 32'(on));
    endtask

    // One clock: advance the model on the edge, compare both DUTs on the falling edge.
    task automatic cyc1();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cmp_one(0, b1.pwm_l, b1.pwm_r, b1.duty_l, b1.duty_r, b1.period_end, b1.busy);
        cmp_one(1, b4.pwm_l, b4.pwm_r, b4.duty_l, b4.duty_r, b4.period_end, b4.busy);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc1();
    endtask

    typedef struct {
        logic [3:0] speed;
        logic [3:0] dir;
        int         dl;
        int         dr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int nhl, nhr, npe, first, run, maxrun;

        tbl[0] = '{4'd10, 4'd8,  10, 10};
        tbl[1] = '{4'd12, 4'd12, 15, 8};
        tbl[2] = '{4'd2,  4'd0,  0,  10};
        tbl[3] = '{4'd15, 4'd15, 15, 8};
        tbl[4] = '{4'd0,  4'd15, 7,  0};
        tbl[5] = '{4'd0,  4'd0,  0,  8};
        tbl[6] = '{4'd15, 4'd0,  7,  15};

        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_cyc[k] = 0; m_dl[k] = 0; m_dr[k] = 0;
        end

        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        cycles(2);
        check("rst_busy", 32'(b1.busy | b4.busy), 0);
        check("rst_pwm", 32'({b1.pwm_l, b1.pwm_r, b4.pwm_l, b4.pwm_r}), 0);
        check("rst_duty", 32'({b1.duty_l, b1.duty_r, b4.duty_l, b4.duty_r}), 0);
        check("rst_pe", 32'(b1.period_end | b4.period_end), 0);

        // Mixer/clamp table: duties appear one cycle after enable, pwm high count == duty.
        foreach (tbl[i]) begin
            rst = 1'b0; en = 1'b0;
            cyc1();
            rst = 1'b1; en = 1'b1; speed = tbl[i].speed; dir = tbl[i].dir;
            cyc1();
            check($sformatf("tbl%0d_duty_l", i), 32'(b1.duty_l), tbl[i].dl);
            check($sformatf("tbl%0d_duty_r", i), 32'(b1.duty_r), tbl[i].dr);
            nhl = 0; nhr = 0;
            for (int c = 0; c < 15; c++) begin
                nhl += int'(b1.pwm_l);
                nhr += int'(b1.pwm_r);
                cyc1();
            end
            check($sformatf("tbl%0d_high_l", i), nhl, tbl[i].dl);
            check($sformatf("tbl%0d_high_r", i), nhr, tbl[i].dr);
        end

        // Basic waveform at presc=1, duty 10.
        rst = 1'b0; en = 1'b0;
        cyc1();
        rst = 1'b1; en = 1'b1; speed = 4'd10; dir = 4'd8;
        cyc1();
        check("lat_busy", 32'(b1.busy), 1);
        for (int c = 0; c < 15; c++) begin
            check($sformatf("wave_pwm_c%0d", c), 32'(b1.pwm_l), 32'(c < 10));
            check($sformatf("wave_pe_c%0d", c), 32'(b1.period_end), 32'(c == 14));
            cyc1();
        end

        // Mid-period command change is deferred to the next period.
        cycles(5);
        speed = 4'd3;
        for (int c = 5; c < 15; c++) begin
            check($sformatf("hold_duty_c%0d", c), 32'(b1.duty_l), 10);
            cyc1();
        end
        check("next_duty_l", 32'(b1.duty_l), 3);
        check("next_duty_r", 32'(b1.duty_r), 3);

        // Disable at slot 4: drain the period, OFF for one cycle, then restart.
        speed = 4'd10;
        cycles(15);
        cycles(4);
        en = 1'b0;
        cyc1();
        en = 1'b1;
        for (int c = 5; c < 15; c++) begin
            check($sformatf("drain_busy_c%0d", c), 32'(b1.busy), 1);
            check($sformatf("drain_pwm_c%0d", c), 32'(b1.pwm_l), 32'(c < 10));
            check($sformatf("drain_pe_c%0d", c), 32'(b1.period_end), 32'(c == 14));
            cyc1();
        end
        check("drain_off_busy", 32'(b1.busy), 0);
        check("drain_off_pwm", 32'({b1.pwm_l, b1.pwm_r}), 0);
        check("drain_off_duty", 32'(b1.duty_l), 0);
        cyc1();
        check("drain_rerun_busy", 32'(b1.busy), 1);
        check("drain_rerun_duty", 32'(b1.duty_l), 10);

        // Reset mid-run at slot 7.
        cycles(7);
        rst = 1'b0;
        cyc1();
        check("midrst_outs", 32'({b1.pwm_l, b1.pwm_r, b1.period_end, b1.busy, b1.duty_l, b1.duty_r}), 0);
        rst = 1'b1; en = 1'b1;
        cyc1();
        check("midrst_busy", 32'(b1.busy), 1);
        check("midrst_pwm", 32'(b1.pwm_l), 1);
        check("midrst_duty", 32'(b1.duty_l), 10);

        // presc=4: 60-cycle period, duty 5 -> 20-cycle high pulse.
        rst = 1'b0;
        cyc1();
        rst = 1'b1; en = 1'b1; speed = 4'd5; dir = 4'd8;
        cyc1();
        npe = 0; first = -1; run = 0; maxrun = 0;
        for (int c = 0; c < 120; c++) begin
            if (b4.period_end) begin
                npe++;
                if (first < 0) first = c;
            end
            run = b4.pwm_l ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            cyc1();
        end
        check("p4_pe_count", npe, 2);
        check("p4_pe_first", first, 59);
        check("p4_high_run", maxrun, 20);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            speed = 4'($urandom_range(0, 15));
            dir = 4'($urandom_range(0, 15));
            cyc1();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 SHALL provide parameter cmd_l, default 4: width of the command and duty fields.
REQ-002 SHALL provide parameter def_dir_cmd, default 8: the direction command value meaning straight ahead.
REQ-003 SHALL provide parameter presc, default 4, legal range >=1: clk cycles per PWM slot.
REQ-004 SHALL provide port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL provide port en  input  1  drive enable.
REQ-007 SHALL provide port speed_cmd  input  cmd_l  processed speed command from the proportional command controller.
REQ-008 SHALL provide port dir_cmd  input  cmd_l  processed direction command from the proportional command controller.
REQ-009 SHALL provide port pwm_l  output  1  left motor PWM.
REQ-010 SHALL provide port pwm_r  output  1  right motor PWM.
REQ-011 SHALL provide port duty_l  output  cmd_l  currently applied left duty.
REQ-012 SHALL provide port duty_r  output  cmd_l  currently applied right duty.
REQ-013 SHALL provide port period_end  output  1  one-cycle pulse on the last clk cycle of each PWM period.
REQ-014 SHALL provide port busy  output  1  high whenever the state is not OFF.

Function
REQ-015 SHALL define MAX = 2^cmd_l - 1 (15 at default).
REQ-016 SHALL mix the commands as follows:
- turn = dir_cmd - def_dir_cmd, signed, range -8..+7 at default.
- left_raw = speed_cmd + turn.
- right_raw = speed_cmd - turn.
- Signed intermediates SHALL be at least cmd_l+2 bits wide.
REQ-017 SHALL clamp left_raw and right_raw to 0..MAX, with no wrap-around.
REQ-018 SHALL implement a prescaler pre_cnt that counts 0..presc-1 and wraps; tick is high when pre_cnt = presc-1.
REQ-019 SHALL implement a slot counter slot that counts 0..MAX-1, advances on tick and wraps to 0.
- PWM period = MAX*presc clk cycles.
REQ-020 SHALL assert period_end for exactly one cycle when tick=1 and slot=MAX-1, in RUN or DRAIN only.
REQ-021 SHALL drive the PWM outputs as pwm_x = (state RUN or DRAIN) and (slot < duty_x).
- Duty 0 gives a constant low output.
- Duty MAX gives a constant high output.
REQ-022 SHALL load duty_l and duty_r only on two events:
- the OFF->RUN transition cycle;
- any cycle where period_end=1 and the next state is RUN.
Input changes mid-period SHALL NOT affect the current period.
REQ-023 SHALL implement a state machine with states OFF, RUN and DRAIN.
REQ-024 In OFF, the block SHALL hold pre_cnt=0, slot=0, both PWM outputs low and both duties 0.
- If en=1, the next state SHALL be RUN.
- On that transition the duties SHALL be loaded from the mixer.
REQ-025 In RUN, the block SHALL apply en as follows:
- en=0 at any cycle → DRAIN next cycle, with duties held.
- Otherwise remain in RUN.
REQ-026 In DRAIN, the block SHALL finish the current period with the held duties, then go to OFF on period_end regardless of en.
- If en=1 in OFF, RUN follows one cycle later.
REQ-027 Latency: with en sampled high in OFF at cycle N, the block SHALL be in RUN at N+1 with slot=0 and the PWM outputs reflecting the loaded duties.
REQ-028 SHALL generate all outputs from registers or from state and counter comparisons only, with no combinational path from speed_cmd or dir_cmd to any output.

Reset
REQ-029 When rst=0 at a rising clk edge, the block SHALL go to state OFF and clear pre_cnt, slot, duty_l and duty_r to 0.
- pwm_l, pwm_r, period_end and busy SHALL all be 0.
REQ-030 Reset SHALL override every other input, including mid-period in RUN or DRAIN.
- The next cycle after reset deasserts is OFF-state behaviour.

Verification
REQ-031 presc=1, speed=10, dir=8, en=1 → duty_l=duty_r=10; each 15-cycle period has pwm high for cycles 0-9 and low for 10-14; period_end is high on cycle 14.
REQ-032 speed=12, dir=12 → left 16 clamped to duty_l=15 (pwm_l constant high), duty_r=8; speed=2, dir=0 → left -6 clamped to duty_l=0 (pwm_l constant low), duty_r=10.
REQ-033 In RUN at slot 5, speed changes from 10 to 3 → duty stays 10 until period_end; the next period shows duty=3.
REQ-034 In RUN, en drops at slot 4 → busy stays high and the PWM continues to slot 14; period_end pulses; the block goes to OFF the next cycle with outputs low. With en held high through DRAIN, the block is in RUN one cycle after OFF.
REQ-035 rst=0 asserted mid-RUN at slot 7 with duty 10 → on the next cycle all outputs are 0 and the state is OFF; after rst returns to 1 with en=1, RUN starts at slot 0 one cycle later.
REQ-036 presc=4 → the period is 60 cycles and period_end pulses once every 60 cycles; duty=5 gives pwm high for 20 consecutive cycles.
